// File: rtl/i2c_mst_arb.sv
// Round-robin arbiter/sequencer sharing one i2c_master among NREQ requesters; grant one cycle after req.
// Optional `I2C_ARB_RUN_TIMEOUT_EN aborts a transaction whose busy stays high for RUN_TO cycles.
module i2c_mst_arb #(
  parameter int NREQ      = 2,
  parameter int LAUNCH_TO = 255,
  parameter int RUN_TO    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*7-1:0]     req_adr,
  input  logic [NREQ-1:0]       req_rw,
  input  logic [NREQ*4-1:0]     req_len,
  input  logic [NREQ*128-1:0]   req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [127:0]          rdata,
  output logic [15:0]           mst_ctrl,
  output logic [127:0]          mst_wfifo,
  input  logic [127:0]          mst_rfifo,
  input  logic [7:0]            mst_status
);

  localparam int TO_MAX = (LAUNCH_TO > RUN_TO) ? LAUNCH_TO : RUN_TO;
  localparam int CW     = $clog2(TO_MAX + 1);
  localparam int IW     = $clog2(NREQ);
  localparam logic [CW-1:0] LAUNCH_LAST = CW'(LAUNCH_TO - 1);
`ifdef I2C_ARB_RUN_TIMEOUT_EN
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_TO - 1);
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            err_q, err_d;
  logic [127:0]    rdata_q, rdata_d, wfifo_q, wfifo_d;
  logic [15:0]     ctrl_q, ctrl_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

  logic            win_vld;
  logic [IW-1:0]   win_idx, cand;
  logic [6:0]      sel_adr;
  logic            sel_rw;
  logic [3:0]      sel_len;
  logic [127:0]    sel_wdata;
  logic            busy;
  logic            unused_status;

  assign busy          = mst_status[7];
  assign unused_status = ^mst_status[6:0];
  assign cnt_inc       = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  // Search starts one past the last winner, so a just-served requester goes last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    sel_adr   = '0;
    sel_rw    = 1'b0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_adr   = req_adr[i*7 +: 7];
        sel_rw    = req_rw[i];
        sel_len   = req_len[i*4 +: 4];
        sel_wdata = req_wdata[i*128 +: 128];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    ctrl_d  = ctrl_q;
    wfifo_d = wfifo_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d          = S_LAUNCH;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          ptr_d            = win_idx;
          ctrl_d           = {sel_adr, sel_rw, 1'b1, 3'b000, sel_len};
          wfifo_d          = sel_wdata;
          cnt_d            = '0;
        end
      end
      S_LAUNCH: begin
        if (busy) begin
          state_d   = S_RUN;
          ctrl_d[7] = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q >= LAUNCH_LAST) begin
          state_d   = S_DONE;
          ctrl_d[7] = 1'b0;
          err_d     = 1'b1;
          done_d    = gnt_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
        // Busy falling wins over a coincident run timeout.
        if (!busy) begin
          state_d = S_DONE;
          rdata_d = mst_rfifo;
          done_d  = gnt_q;
        end
`ifdef I2C_ARB_RUN_TIMEOUT_EN
        else if (cnt_q >= RUN_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ctrl_q  <= '0;
      wfifo_q <= '0;
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ctrl_q  <= ctrl_d;
      wfifo_q <= wfifo_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mst_ctrl  = ctrl_q;
  assign mst_wfifo = wfifo_q;

endmodule

// File: tb/tb_i2c_mst_arb.sv
// Bench for i2c_mst_arb: i2c_master stub, transaction-rule model checked every cycle, directed scenarios.
`timescale 1ns/1ps
module tb_i2c_mst_arb;
  localparam int NREQ = 2;
  localparam int LTO  = 10;
  localparam int RTO  = 20;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*7-1:0]   req_adr = '0;
  logic [NREQ-1:0]     req_rw = '0;
  logic [NREQ*4-1:0]   req_len = '0;
  logic [NREQ*128-1:0] req_wdata = '0;
  logic [NREQ-1:0]     gnt, done;
  logic                err;
  logic [127:0]        rdata, mst_wfifo;
  logic [127:0]        mst_rfifo = '0;
  logic [15:0]         mst_ctrl;
  logic [7:0]          mst_status;
  logic                busy = 1'b0;

  int checks = 0;
  int errors = 0;

  assign mst_status = {busy, 7'h55};

  i2c_mst_arb #(.NREQ(NREQ), .LAUNCH_TO(LTO), .RUN_TO(RTO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_adr(req_adr), .req_rw(req_rw),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
    .rdata(rdata), .mst_ctrl(mst_ctrl), .mst_wfifo(mst_wfifo),
    .mst_rfifo(mst_rfifo), .mst_status(mst_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // i2c_master stub: busy rises sl_dly cycles after rdy is seen and stays up sl_len cycles.
  logic sl_en = 1'b0;
  int   sl_dly = 3, sl_len = 40, sl_wait = 0, sl_run = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      busy = 1'b0; sl_wait = 0; sl_run = 0;
    end else if (busy) begin
      sl_run++;
      if (sl_run >= sl_len) begin busy = 1'b0; sl_run = 0; end
    end else if (mst_ctrl[7] && sl_en) begin
      sl_wait++;
      if (sl_wait > sl_dly) begin busy = 1'b1; sl_wait = 0; sl_run = 0; end
    end else begin
      sl_wait = 0;
    end
  end

  // Model: expected outputs after the next edge, derived from the transaction rules.
  localparam int M_IDLE = 0, M_LAUNCH = 1, M_RUN = 2, M_DONE = 3;
  int              m_st = M_IDLE, m_win = 0, m_ptr = NREQ - 1, m_cnt = 0, cand = 0;
  logic            m_valid = 1'b0;
  logic [15:0]     m_ctrl = '0;
  logic [127:0]    m_wfifo = '0, m_rdata = '0;
  logic            m_err = 1'b0;
  logic [NREQ-1:0] m_done = '0, m_gnt, prev_gnt = '0;
  int              glog[$];

  always @(negedge clk) begin
    if (m_valid) begin
      m_gnt = '0;
      if (m_st != M_IDLE) m_gnt[m_win] = 1'b1;
      chk("gnt", gnt, m_gnt);
      chk("gnt_onehot", $countones(gnt) <= 1, 1);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("rdata", rdata, m_rdata);
      chk("mst_ctrl", mst_ctrl, m_ctrl);
      chk("mst_wfifo", mst_wfifo, m_wfifo);
      if (prev_gnt == '0 && gnt != '0)
        for (int i = 0; i < NREQ; i++) if (gnt[i]) glog.push_back(i);
      prev_gnt = gnt;
    end
    if (rst) begin
      m_valid = 1'b1; m_st = M_IDLE; m_ptr = NREQ - 1; m_ctrl = '0; m_wfifo = '0;
      m_rdata = '0; m_err = 1'b0; m_done = '0; m_win = 0;
    end else if (m_valid) begin
      m_done = '0;
      case (m_st)
        M_IDLE:
          for (int k = 1; k <= NREQ; k++) begin
            cand = (m_ptr + k) % NREQ;
            if (m_st == M_IDLE && req[cand]) begin
              m_win   = cand;
              m_ptr   = cand;
              m_ctrl  = {req_adr[cand*7 +: 7], req_rw[cand], 1'b1, 3'b000, req_len[cand*4 +: 4]};
              m_wfifo = req_wdata[cand*128 +: 128];
              m_cnt   = 0;
              m_st    = M_LAUNCH;
            end
          end
        M_LAUNCH: begin
          m_cnt++;
          if (busy) begin
            m_ctrl[7] = 1'b0; m_cnt = 0; m_st = M_RUN;
          end else if (m_cnt >= LTO) begin
            m_ctrl[7] = 1'b0; m_err = 1'b1; m_done[m_win] = 1'b1; m_st = M_DONE;
          end
        end
        M_RUN: begin
          m_cnt++;
          if (!busy) begin
            m_rdata = mst_rfifo; m_done[m_win] = 1'b1; m_st = M_DONE;
          end
`ifdef I2C_ARB_RUN_TIMEOUT_EN
          else if (m_cnt >= RTO) begin
            m_err = 1'b1; m_done[m_win] = 1'b1; m_st = M_DONE;
          end
`endif
        end
        default: begin
          m_err = 1'b0; m_st = M_IDLE;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    while (done == '0 && cyc < 200) begin tick(); cyc++; end
    if (done == '0) begin
      checks++; errors++;
      $display("FAIL %s: no done within %0d cycles, required a done pulse", nm, cyc);
    end
  endtask

  task automatic count_rdy(output int n);
    n = 0;
    while (mst_ctrl[7] && n < 100) begin n++; tick(); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, nd;
    logic [127:0] r0;
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_ctrl", mst_ctrl, 16'h0000);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // 1: single write from requester 0; fields changed after grant must be ignored
    sl_en = 1'b1; sl_dly = 3; sl_len = 40;
    req_adr[6:0] = 7'h2d; req_rw[0] = 1'b0; req_len[3:0] = 4'hf;
    req_wdata[127:0] = {16{8'h5a}}; mst_rfifo = 128'hfeed;
    req[0] = 1'b1;
    tick();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_ctrl_launch", mst_ctrl, 16'h5a8f);
    chk("t1_wfifo", mst_wfifo, {16{8'h5a}});
    req[0] = 1'b0; req_adr[6:0] = 7'h11;
    count_rdy(n);
    chk("t1_rdy_cycles", n, 4);
    chk("t1_ctrl_run", mst_ctrl, 16'h5a0f);
    wait_done("t1_wait", m);
    chk("t1_run_cycles", m, 40);
    chk("t1_done", done, 2'b01);
    chk("t1_err", err, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_gnt_clear", gnt, 0);

    // 2: read from requester 1
    sl_dly = 1; sl_len = 5;
    req_adr[13:7] = 7'h2d; req_rw[1] = 1'b1; req_len[7:4] = 4'hf;
    mst_rfifo = 128'h0123456789abcdef0123456789abcdef;
    req[1] = 1'b1;
    tick();
    chk("t2_gnt", gnt, 2'b10);
    chk("t2_ctrl", mst_ctrl, 16'h5b8f);
    req[1] = 1'b0;
    wait_done("t2_wait", m);
    chk("t2_done", done, 2'b10);
    chk("t2_rdata", rdata, 128'h0123456789abcdef0123456789abcdef);
    chk("t2_err", err, 0);
    tick();

    // 3: contention, both requesting for four transactions
    glog.delete();
    req = 2'b11; nd = 0; m = 0;
    while (nd < 4 && m < 1000) begin
      tick(); m++;
      if (done != '0) nd++;
    end
    req = '0;
    repeat (3) tick();
    chk("t3_ndone", nd, 4);
    chk("t3_ngrants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("t3_order0", glog[0], 0);
      chk("t3_order1", glog[1], 1);
      chk("t3_order2", glog[2], 0);
      chk("t3_order3", glog[3], 1);
    end

    // 4: launch timeout, busy never rises
    sl_en = 1'b0;
    req[0] = 1'b1;
    tick();
    chk("t4_gnt", gnt, 2'b01);
    req[0] = 1'b0;
    count_rdy(n);
    chk("t4_rdy_cycles", n, 10);
    chk("t4_done", done, 2'b01);
    chk("t4_err", err, 1);
    tick();

    // 5: reset while running
    sl_en = 1'b1; sl_dly = 1; sl_len = 40;
    req[1] = 1'b1;
    tick();
    chk("t5_gnt", gnt, 2'b10);
    req[1] = 1'b0;
    count_rdy(n);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t5_gnt_rst", gnt, 0);
    chk("t5_ctrl_rst", mst_ctrl, 16'h0000);
    chk("t5_done_rst", done, 0);
    rst = 1'b0; req = 2'b11;
    tick();
    chk("t5_ptr_reset", gnt, 2'b01);
    req = '0;
    wait_done("t5_wait", m);
    chk("t5_done", done, 2'b01);
    tick();

`ifdef I2C_ARB_RUN_TIMEOUT_EN
    // 6: busy stuck high, run timeout
    sl_dly = 1; sl_len = 100000;
    r0 = rdata;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    count_rdy(n);
    wait_done("t6_wait", m);
    chk("t6_run_cycles", m, 20);
    chk("t6_done", done, 2'b01);
    chk("t6_err", err, 1);
    chk("t6_rdata_kept", rdata, r0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`else
    r0 = '0;
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
